// File: rtl/rs_regs_pkg.sv
// rs_regs_pkg -- shared definitions for the RS encoder/decoder register block.
// Holds the register index map, bit positions inside each register, the
// AXI4-Lite response codes and the write/read channel state encodings.
package rs_regs_pkg;

   // Register indices (byte address >> 2)
   localparam int IDX_CTRL      = 0;
   localparam int IDX_STATUS    = 1;
   localparam int IDX_ERRCNT    = 2;
   localparam int IDX_IRQ_FORCE = 3;

   // CTRL bits
   localparam int CTRL_ENC_START = 0;
   localparam int CTRL_DEC_START = 1;
   localparam int CTRL_ENC_IE    = 8;
   localparam int CTRL_DEC_IE    = 9;

   // STATUS bits
   localparam int ST_ENC_BUSY = 0;
   localparam int ST_DEC_BUSY = 1;
   localparam int ST_ENC_DONE = 8;
   localparam int ST_DEC_DONE = 9;
   localparam int ST_DEC_FAIL = 10;

   // IRQ_FORCE bits
   localparam int IRQF_ENC = 0;
   localparam int IRQF_DEC = 1;

   localparam int ERRCNT_W = 4;

   // AXI4-Lite response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/rs_axil_regs.sv
// rs_axil_regs -- AXI4-Lite control/status register block for an RS codec.
//
// Registers (index = addr >> 2):
//   0 CTRL   : b0 ENC_START, b1 DEC_START (self-clearing, read 0), b8 ENC_IE, b9 DEC_IE
//   1 STATUS : b0 ENC_BUSY, b1 DEC_BUSY, b8 ENC_DONE (W1C), b9 DEC_DONE (W1C), b10 DEC_FAIL
//   2 ERRCNT : b3:0 corrected-symbol count of the last decode
//   3 IRQ_FORCE (write-only, reads 0) -- only when RS_REGS_IRQ_TEST_EN is defined;
//     otherwise index 3 is unmapped and answers SLVERR.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   aw*/w*/b*/ar*/r*      AXI4-Lite slave
//   enc_start, dec_start  one-cycle start pulses to the codec
//   enc_done, dec_done    one-cycle completion pulses from the codec
//   dec_fail, dec_err_cnt decode result, qualified by dec_done
//   RS_E_interrupt        registered (ENC_DONE & ENC_IE), or forced
//   RS_D_interrupt        registered (DEC_DONE & DEC_IE), or forced
module rs_axil_regs
   import rs_regs_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                aclk,
   input  logic                areset,
   // write address
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   // write data
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wvalid,
   output logic                wready,
   // write response
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   // read address
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   // read data
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready,
   // codec handshake
   output logic                enc_start,
   output logic                dec_start,
   input  logic                enc_done,
   input  logic                dec_done,
   input  logic                dec_fail,
   input  logic [ERRCNT_W-1:0] dec_err_cnt,
   output logic                RS_E_interrupt,
   output logic                RS_D_interrupt
);

`ifdef RS_REGS_IRQ_TEST_EN
   localparam int IDX_LAST = IDX_IRQ_FORCE;
`else
   localparam int IDX_LAST = IDX_ERRCNT;
`endif

   // ---------------------------------------------------------------- state
   w_state_t            w_state_q, w_state_d;
   r_state_t            r_state_q, r_state_d;
   logic                aw_seen_q, aw_seen_d;
   logic                w_seen_q,  w_seen_d;
   logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
   logic [DATA_W-1:0]   wdata_q,   wdata_d;
   logic [DATA_W/8-1:0] wstrb_q,   wstrb_d;
   logic [1:0]          bresp_q,   bresp_d;
   logic [DATA_W-1:0]   rdata_q,   rdata_d;
   logic [1:0]          rresp_q,   rresp_d;

   logic                enc_ie_q,   enc_ie_d;
   logic                dec_ie_q,   dec_ie_d;
   logic                enc_busy_q, enc_busy_d;
   logic                dec_busy_q, dec_busy_d;
   logic                enc_done_q, enc_done_d;
   logic                dec_done_q, dec_done_d;
   logic                dec_fail_q, dec_fail_d;
   logic [ERRCNT_W-1:0] errcnt_q,   errcnt_d;
   logic                enc_start_q, enc_start_d;
   logic                dec_start_q, dec_start_d;
   logic                irq_e_q,    irq_e_d;
   logic                irq_d_q,    irq_d_d;

   // ------------------------------------------------------ write channel
   logic                aw_hs, w_hs, commit, w_ok;
   logic [ADDR_W-1:0]   wa, w_idx;
   logic [DATA_W-1:0]   wd;
   logic [DATA_W/8-1:0] ws;

   always_comb begin
      awready = (w_state_q == W_IDLE) && !aw_seen_q;
      wready  = (w_state_q == W_IDLE) && !w_seen_q;
      bvalid  = (w_state_q == W_RESP);
      bresp   = bresp_q;

      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;

      // Use the latched half if it arrived earlier, else the live bus.
      wa = aw_seen_q ? awaddr_q : awaddr;
      wd = w_seen_q  ? wdata_q  : wdata;
      ws = w_seen_q  ? wstrb_q  : wstrb;

      w_idx  = wa >> 2;
      w_ok   = (w_idx <= ADDR_W'(IDX_LAST));
      commit = (w_state_q == W_IDLE) && (aw_seen_q || aw_hs) && (w_seen_q || w_hs);

      w_state_d = w_state_q;
      aw_seen_d = aw_seen_q;
      w_seen_d  = w_seen_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;

      case (w_state_q)
         W_IDLE: begin
            if (commit) begin
               w_state_d = W_RESP;
               aw_seen_d = 1'b0;
               w_seen_d  = 1'b0;
               bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
               if (aw_hs) begin
                  aw_seen_d = 1'b1;
                  awaddr_d  = awaddr;
               end
               if (w_hs) begin
                  w_seen_d = 1'b1;
                  wdata_d  = wdata;
                  wstrb_d  = wstrb;
               end
            end
         end
         W_RESP: if (bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // ---------------------------------------------------- register update
   logic wr_ctrl, wr_status, enc_go, dec_go;
`ifdef RS_REGS_IRQ_TEST_EN
   logic wr_force;
`endif

   always_comb begin
      wr_ctrl   = commit && w_ok && (w_idx[1:0] == 2'(IDX_CTRL));
      wr_status = commit && w_ok && (w_idx[1:0] == 2'(IDX_STATUS));

      enc_ie_d   = enc_ie_q;
      dec_ie_d   = dec_ie_q;
      enc_busy_d = enc_busy_q;
      dec_busy_d = dec_busy_q;
      enc_done_d = enc_done_q;
      dec_done_d = dec_done_q;
      dec_fail_d = dec_fail_q;
      errcnt_d   = errcnt_q;

      if (wr_ctrl && ws[CTRL_ENC_IE/8]) begin
         enc_ie_d = wd[CTRL_ENC_IE];
         dec_ie_d = wd[CTRL_DEC_IE];
      end

      // A start request while the engine is busy is dropped silently.
      enc_go = wr_ctrl && ws[CTRL_ENC_START/8] && wd[CTRL_ENC_START] && !enc_busy_q;
      dec_go = wr_ctrl && ws[CTRL_DEC_START/8] && wd[CTRL_DEC_START] && !dec_busy_q;
      enc_start_d = enc_go;
      dec_start_d = dec_go;

      if (enc_go)        enc_busy_d = 1'b1;
      else if (enc_done) enc_busy_d = 1'b0;
      if (dec_go)        dec_busy_d = 1'b1;
      else if (dec_done) dec_busy_d = 1'b0;

      // Hardware completion wins over a simultaneous W1C.
      if (enc_done)
         enc_done_d = 1'b1;
      else if (wr_status && ws[ST_ENC_DONE/8] && wd[ST_ENC_DONE])
         enc_done_d = 1'b0;

      if (dec_done) begin
         dec_done_d = 1'b1;
         dec_fail_d = dec_fail;
         errcnt_d   = dec_err_cnt;
      end else if (wr_status && ws[ST_DEC_DONE/8] && wd[ST_DEC_DONE]) begin
         dec_done_d = 1'b0;
         dec_fail_d = 1'b0;
      end

      irq_e_d = enc_done_q && enc_ie_q;
      irq_d_d = dec_done_q && dec_ie_q;
`ifdef RS_REGS_IRQ_TEST_EN
      wr_force = commit && w_ok && (w_idx[1:0] == 2'(IDX_IRQ_FORCE));
      if (wr_force && ws[0]) begin
         irq_e_d = irq_e_d || wd[IRQF_ENC];
         irq_d_d = irq_d_d || wd[IRQF_DEC];
      end
`endif
   end

   // ------------------------------------------------------- read channel
   logic [ADDR_W-1:0] r_idx;
   logic [DATA_W-1:0] rd_val;

   always_comb begin
      arready = (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_DATA);
      rdata   = rdata_q;
      rresp   = rresp_q;

      r_idx  = araddr >> 2;
      rd_val = '0;
      case (r_idx[1:0])
         2'(IDX_CTRL): begin
            rd_val[CTRL_ENC_IE] = enc_ie_q;
            rd_val[CTRL_DEC_IE] = dec_ie_q;
         end
         2'(IDX_STATUS): begin
            rd_val[ST_ENC_BUSY] = enc_busy_q;
            rd_val[ST_DEC_BUSY] = dec_busy_q;
            rd_val[ST_ENC_DONE] = enc_done_q;
            rd_val[ST_DEC_DONE] = dec_done_q;
            rd_val[ST_DEC_FAIL] = dec_fail_q;
         end
         2'(IDX_ERRCNT): rd_val[ERRCNT_W-1:0] = errcnt_q;
         default: rd_val = '0;
      endcase

      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            // Sampled from the _q registers, so a write committing on the
            // same edge is not yet visible.
            if (arvalid) begin
               r_state_d = R_DATA;
               if (r_idx <= ADDR_W'(IDX_LAST)) begin
                  rdata_d = rd_val;
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         R_DATA: if (rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   logic unused_ok;
   assign unused_ok = ^{wd, ws, wa[1:0], araddr[1:0]};

   // ------------------------------------------------------------ registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_q   <= W_IDLE;
         r_state_q   <= R_IDLE;
         aw_seen_q   <= 1'b0;
         w_seen_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         bresp_q     <= RESP_OKAY;
         rdata_q     <= '0;
         rresp_q     <= RESP_OKAY;
         enc_ie_q    <= 1'b0;
         dec_ie_q    <= 1'b0;
         enc_busy_q  <= 1'b0;
         dec_busy_q  <= 1'b0;
         enc_done_q  <= 1'b0;
         dec_done_q  <= 1'b0;
         dec_fail_q  <= 1'b0;
         errcnt_q    <= '0;
         enc_start_q <= 1'b0;
         dec_start_q <= 1'b0;
         irq_e_q     <= 1'b0;
         irq_d_q     <= 1'b0;
      end else begin
         w_state_q   <= w_state_d;
         r_state_q   <= r_state_d;
         aw_seen_q   <= aw_seen_d;
         w_seen_q    <= w_seen_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         bresp_q     <= bresp_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         enc_ie_q    <= enc_ie_d;
         dec_ie_q    <= dec_ie_d;
         enc_busy_q  <= enc_busy_d;
         dec_busy_q  <= dec_busy_d;
         enc_done_q  <= enc_done_d;
         dec_done_q  <= dec_done_d;
         dec_fail_q  <= dec_fail_d;
         errcnt_q    <= errcnt_d;
         enc_start_q <= enc_start_d;
         dec_start_q <= dec_start_d;
         irq_e_q     <= irq_e_d;
         irq_d_q     <= irq_d_d;
      end
   end

   assign enc_start      = enc_start_q;
   assign dec_start      = dec_start_q;
   assign RS_E_interrupt = irq_e_q;
   assign RS_D_interrupt = irq_d_q;

endmodule

// File: tb/tb_rs_axil_regs.sv
// Directed testbench for rs_axil_regs. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at that same point.
module tb_rs_axil_regs;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb, dec_err_cnt;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic        enc_start, dec_start, enc_done, dec_done, dec_fail;
   logic        RS_E_interrupt, RS_D_interrupt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 aclk = ~aclk;

   rs_axil_regs #(.ADDR_W(32), .DATA_W(32)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .enc_start(enc_start), .dec_start(dec_start),
      .enc_done(enc_done), .dec_done(dec_done),
      .dec_fail(dec_fail), .dec_err_cnt(dec_err_cnt),
      .RS_E_interrupt(RS_E_interrupt), .RS_D_interrupt(RS_D_interrupt)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for bvalid, captures the response and the pulse/irq
   // outputs seen in that cycle, then accepts the response.
   task automatic wait_b(output logic [1:0] resp, output logic [3:0] caps);
      int n = 0;
      while (bvalid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk("bvalid_seen", 32'(bvalid), 32'd1);
      resp = bresp;
      caps = {RS_D_interrupt, RS_E_interrupt, dec_start, enc_start};
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [3:0] caps);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      wait_b(resp, caps);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      araddr = addr; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      while (rvalid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk("rvalid_seen", 32'(rvalid), 32'd1);
      data = rdata;
      resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [3:0]  caps;
      logic [31:0] rd;

      {awvalid, wvalid, bready, arvalid, rready, enc_done, dec_done, dec_fail} = '0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; dec_err_cnt = '0;

      // ---- reset state
      areset = 1'b1;
      tick(); tick();
      areset = 1'b0;
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_wready",  32'(wready),  32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_bvalid",  32'(bvalid),  32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_starts",  32'({dec_start, enc_start}), 32'd0);
      chk("rst_irqs",    32'({RS_D_interrupt, RS_E_interrupt}), 32'd0);
      axi_read(32'h0, rd, resp); chk("rst_ctrl",   rd, 32'h0);
      axi_read(32'h4, rd, resp); chk("rst_status", rd, 32'h0);
      axi_read(32'h8, rd, resp); chk("rst_errcnt", rd, 32'h0);

      // ---- encoder start / busy / done / interrupt
      axi_write(32'h0, 32'h301, 4'hF, resp, caps);
      chk("ctrl_wr_resp",   32'(resp), 32'd0);
      chk("enc_start_hi",   32'(caps[0]), 32'd1);
      chk("dec_start_lo",   32'(caps[1]), 32'd0);
      chk("enc_start_1cyc", 32'(enc_start), 32'd0);
      axi_read(32'h0, rd, resp); chk("ctrl_rb_start0", rd, 32'h300);
      axi_read(32'h4, rd, resp); chk("status_enc_busy", rd, 32'h1);
      axi_write(32'h0, 32'h301, 4'hF, resp, caps);
      chk("busy_start_resp",  32'(resp), 32'd0);
      chk("busy_start_nopls", 32'(caps[0]), 32'd0);
      axi_read(32'h4, rd, resp); chk("status_still_busy", rd, 32'h1);
      enc_done = 1'b1; tick(); enc_done = 1'b0;
      chk("irq_e_latency", 32'(RS_E_interrupt), 32'd0);
      tick();
      chk("irq_e_set", 32'(RS_E_interrupt), 32'd1);
      axi_read(32'h4, rd, resp); chk("status_enc_done", rd, 32'h100);

      // ---- AW at N, W at N+3
      awaddr = 32'h0; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("aw_latched_awready", 32'(awready), 32'd0);
      chk("aw_latched_wready",  32'(wready),  32'd1);
      chk("b_not_early",        32'(bvalid),  32'd0);
      tick(); tick();
      chk("b_not_n2", 32'(bvalid), 32'd0);
      wdata = 32'h300; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("b_at_n4",    32'(bvalid), 32'd1);
      chk("bresp_okay", 32'(bresp),  32'd0);
      tick(); tick();
      chk("b_hold", 32'(bvalid), 32'd1);
      bready = 1'b1; tick(); bready = 1'b0;
      chk("b_released", 32'(bvalid), 32'd0);

      // ---- byte strobes
      axi_write(32'h0, 32'h0, 4'h1, resp, caps);
      axi_read(32'h0, rd, resp); chk("strb_lane1_kept", rd, 32'h300);
      axi_write(32'h0, 32'h0, 4'h2, resp, caps);
      axi_read(32'h0, rd, resp); chk("strb_lane1_wr", rd, 32'h0);
      chk("irq_e_masked", 32'(RS_E_interrupt), 32'd0);

      // ---- W1C collides with enc_done: set wins
      awaddr = 32'h4; wdata = 32'h100; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; enc_done = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; enc_done = 1'b0;
      wait_b(resp, caps);
      chk("w1c_collide_resp", 32'(resp), 32'd0);
      axi_read(32'h4, rd, resp); chk("w1c_collide_kept", rd, 32'h100);
      axi_write(32'h4, 32'h100, 4'hF, resp, caps);
      axi_read(32'h4, rd, resp); chk("w1c_enc_done", rd, 32'h0);

      // ---- decoder with failure and error count
      axi_write(32'h0, 32'h202, 4'hF, resp, caps);
      chk("dec_start_hi", 32'(caps[1]), 32'd1);
      chk("dec_enc_lo",   32'(caps[0]), 32'd0);
      axi_read(32'h4, rd, resp); chk("status_dec_busy", rd, 32'h2);
      dec_fail = 1'b1; dec_err_cnt = 4'h9; dec_done = 1'b1;
      tick();
      dec_done = 1'b0; dec_fail = 1'b0; dec_err_cnt = 4'h0;
      axi_read(32'h4, rd, resp); chk("status_dec_fail", rd, 32'h600);
      axi_read(32'h8, rd, resp); chk("errcnt_9", rd, 32'h9);
      chk("irq_d_set", 32'(RS_D_interrupt), 32'd1);
      axi_write(32'h8, 32'h0, 4'hF, resp, caps);
      chk("errcnt_ro_resp", 32'(resp), 32'd0);
      axi_read(32'h8, rd, resp); chk("errcnt_ro_kept", rd, 32'h9);
      axi_write(32'h4, 32'h200, 4'hF, resp, caps);
      axi_read(32'h4, rd, resp); chk("w1c_dec_clear", rd, 32'h0);
      chk("irq_d_clear", 32'(RS_D_interrupt), 32'd0);

      // ---- unmapped addresses
      axi_read(32'h1C, rd, resp);
      chk("rd7_resp", 32'(resp), 32'd2);
      chk("rd7_data", rd, 32'h0);
      axi_write(32'h1C, 32'h301, 4'hF, resp, caps);
      chk("wr7_resp",  32'(resp), 32'd2);
      chk("wr7_nopls", 32'(caps[1:0]), 32'd0);
      axi_read(32'h0, rd, resp); chk("wr7_ctrl_kept", rd, 32'h200);
      axi_read(32'h4, rd, resp); chk("wr7_status_kept", rd, 32'h0);
      axi_write(32'hC, 32'h3, 4'hF, resp, caps);
`ifdef RS_REGS_IRQ_TEST_EN
      chk("wr3_resp", 32'(resp), 32'd0);
      chk("wr3_irqs", 32'(caps[3:2]), 32'd3);
      chk("wr3_irqs_1cyc", 32'({RS_D_interrupt, RS_E_interrupt}), 32'd0);
      axi_read(32'hC, rd, resp);
      chk("rd3_resp", 32'(resp), 32'd0);
      chk("rd3_data", rd, 32'h0);
`else
      chk("wr3_resp", 32'(resp), 32'd2);
      chk("wr3_irqs", 32'(caps[3:2]), 32'd0);
      axi_read(32'hC, rd, resp);
      chk("rd3_resp", 32'(resp), 32'd2);
      chk("rd3_data", rd, 32'h0);
`endif

      // ---- read sampled on the write-commit edge sees the old value
      awaddr = 32'h0; wdata = 32'h300; wstrb = 4'hF; araddr = 32'h0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("rw_rvalid",   32'(rvalid), 32'd1);
      chk("rw_prewrite", rdata, 32'h200);
      chk("rw_bvalid",   32'(bvalid), 32'd1);
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      chk("rw_idle", 32'({rvalid, bvalid}), 32'd0);
      axi_read(32'h0, rd, resp); chk("rw_postwrite", rd, 32'h300);

      // ---- reset with a response outstanding
      enc_done = 1'b1; tick(); enc_done = 1'b0;
      tick();
      chk("pre_rst_irq_e", 32'(RS_E_interrupt), 32'd1);
      awaddr = 32'h8; wdata = 32'h0; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
      areset = 1'b1;
      tick();
      chk("midrst_bvalid",  32'(bvalid), 32'd0);
      chk("midrst_irqs",    32'({RS_D_interrupt, RS_E_interrupt}), 32'd0);
      chk("midrst_readies", 32'({awready, wready, arready}), 32'd7);
      areset = 1'b0;
      tick(); tick();
      chk("post_rst_no_b", 32'(bvalid), 32'd0);
      axi_read(32'h0, rd, resp); chk("post_rst_ctrl",   rd, 32'h0);
      axi_read(32'h4, rd, resp); chk("post_rst_status", rd, 32'h0);
      axi_read(32'h8, rd, resp); chk("post_rst_errcnt", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
